// File: rtl/issue_varray_queue_pkg.sv
// Shared types and helpers for the variable-array issue queue: position
// arithmetic on the free-running virtual timeline, the per-channel group
// entry, and the packed latency table lookup.
package issue_varray_queue_pkg;

    localparam int PKG_POS_BITS     = 16;
    localparam int PKG_ADDR_W       = 11;
    localparam int PKG_PAYLOAD_W    = 16;
    localparam int PKG_LOG_MAX_COPY = 4;
    localparam int PKG_MAX_CHANNELS = 16;

    typedef logic [PKG_POS_BITS-1:0] pos_t;

    // One instruction group waiting in a channel FIFO.
    typedef struct packed {
        pos_t                        start;
        logic [PKG_LOG_MAX_COPY:0]   count;
        logic [PKG_ADDR_W-1:0]       base;
        logic [PKG_ADDR_W-1:0]       delta;
        logic [PKG_PAYLOAD_W-1:0]    payload;
    } grp_entry_t;

    // a >= b on the wrapping timeline: the difference read as signed.
    function automatic logic pos_ge(input pos_t a, input pos_t b);
        pos_t d;
        d = a - b;
        return !d[PKG_POS_BITS-1];
    endfunction

    function automatic pos_t pos_max(input pos_t a, input pos_t b);
        return pos_ge(a, b) ? a : b;
    endfunction

    // Channel 0 sits in the least significant 4-bit field.
    function automatic logic [3:0] latency_of(input logic [4*PKG_MAX_CHANNELS-1:0] lat,
                                              input int ch);
        return lat[4*ch +: 4];
    endfunction

endpackage

// File: rtl/issue_varray_queue_fifo.sv
// Per-channel group FIFO: DEPTH entries, registered pointers, head visible
// combinationally from storage. Writes while full are never issued by the top.
module issue_group_fifo
    import issue_varray_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  grp_entry_t push_data,
    input  logic       pop,
    output grp_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    grp_entry_t      mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Pointer update; the extra MSB separates full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/issue_varray_queue.sv
// Instruction group queue on a shared virtual timeline. Each accepted group
// is given a start position honouring the previous group's pipeline latency
// and its own channel's occupancy; the read pointer then walks the timeline
// and each channel expands its head group into per-thread issues.
// The entry struct and position helpers are sized by the package, so the
// width parameters here must stay equal to the package values.
module issue_varray_queue
    import issue_varray_queue_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int PAYLOAD_W    = PKG_PAYLOAD_W,
    parameter int ADDR_W       = PKG_ADDR_W,
    parameter int LOG_MAX_COPY = PKG_LOG_MAX_COPY,
    parameter int DEPTH        = 8,
    parameter int POS_BITS     = PKG_POS_BITS,
    parameter logic [4*NUM_CHANNELS-1:0] LATENCY = {4'd10, 4'd3, 4'd4, 4'd1},
    localparam int CH_W = $clog2(NUM_CHANNELS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [CH_W-1:0]                    in_channel,
    input  logic                               in_barrier,
    input  logic [LOG_MAX_COPY:0]              in_count,
    input  logic [ADDR_W-1:0]                  in_base,
    input  logic [ADDR_W-1:0]                  in_delta,
    input  logic [PAYLOAD_W-1:0]               in_payload,
    input  logic                               re,
    output logic [NUM_CHANNELS-1:0]            out_valid,
    output logic [NUM_CHANNELS*PAYLOAD_W-1:0]  out_payload,
    output logic [NUM_CHANNELS*ADDR_W-1:0]     out_addr,
    output logic [NUM_CHANNELS*LOG_MAX_COPY-1:0] out_thread,
    output logic                               out_barrier,
    output logic                               empty
);

    localparam logic [POS_BITS-1:0] POS_ONE = POS_BITS'(1);
    localparam logic [4*PKG_MAX_CHANNELS-1:0] LAT_EXT = (4*PKG_MAX_CHANNELS)'(LATENCY);

    // Timeline state
    logic [POS_BITS-1:0] read_pos;
    logic [POS_BITS-1:0] next_free [NUM_CHANNELS];
    logic [POS_BITS-1:0] done_pos  [NUM_CHANNELS];
    logic [CH_W-1:0]     prev_ch;
    logic                bar_valid;
    logic [POS_BITS-1:0] bar_start;

    // Channel FIFO plumbing
    grp_entry_t                heads [NUM_CHANNELS];
    grp_entry_t                push_entry;
    logic [NUM_CHANNELS-1:0]   f_full, f_empty, f_push, f_pop;

    // Push scheduling
    logic                accept, grp_push, bar_push;
    logic [POS_BITS-1:0] norm_start, bar_slot, grp_len, lat_in;

    // Issue selection
    logic [NUM_CHANNELS-1:0]                   hit;
    logic [NUM_CHANNELS-1:0][LOG_MAX_COPY-1:0] thread;
    logic                                      bar_hit;

    // Registered outputs
    logic [NUM_CHANNELS-1:0]                   valid_q;
    logic [NUM_CHANNELS-1:0][PAYLOAD_W-1:0]    payload_q;
    logic [NUM_CHANNELS-1:0][ADDR_W-1:0]       addr_q;
    logic [NUM_CHANNELS-1:0][LOG_MAX_COPY-1:0] thread_q;

    assign in_ready = !reset && (in_barrier ? !bar_valid : !f_full[in_channel]);
    assign accept   = in_valid && in_ready;
    assign bar_push = accept && in_barrier;
    // A zero-length group is consumed at the handshake and leaves no trace.
    assign grp_push = accept && !in_barrier && (in_count != '0);
    assign bar_hit  = re && bar_valid && (read_pos == bar_start);

    assign empty       = (&f_empty) && !bar_valid;
    assign out_valid   = valid_q;
    assign out_payload = payload_q;
    assign out_addr    = addr_q;
    assign out_thread  = thread_q;

    // Start slots for a normal push and a barrier push.
    always_comb begin
        grp_len    = POS_BITS'(in_count);
        lat_in     = POS_BITS'(latency_of(LAT_EXT, int'(in_channel)));
        norm_start = pos_max(pos_max(done_pos[prev_ch], next_free[in_channel]),
                             read_pos + POS_ONE);
        bar_slot   = read_pos + POS_ONE;
        for (int c = 0; c < NUM_CHANNELS; c++)
            bar_slot = pos_max(bar_slot, done_pos[c]);
        push_entry         = '0;
        push_entry.start   = norm_start;
        push_entry.count   = in_count;
        push_entry.base    = in_base;
        push_entry.delta   = in_delta;
        push_entry.payload = in_payload;
    end

    // A channel issues when read_pos falls inside its head group's window;
    // the group leaves the FIFO on its last thread.
    always_comb begin
        hit    = '0;
        thread = '0;
        f_pop  = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            thread[c] = LOG_MAX_COPY'(read_pos - heads[c].start);
            hit[c]    = re && !f_empty[c]
                        && pos_ge(read_pos, heads[c].start)
                        && !pos_ge(read_pos, heads[c].start + POS_BITS'(heads[c].count));
            f_pop[c]  = hit[c] && ({1'b0, thread[c]} == heads[c].count - (LOG_MAX_COPY+1)'(1));
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        assign f_push[g] = grp_push && (in_channel == CH_W'(g));

        issue_group_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (f_push[g]),
            .push_data (push_entry),
            .pop       (f_pop[g]),
            .head      (heads[g]),
            .full      (f_full[g]),
            .empty     (f_empty[g])
        );
    end

    // Timeline bookkeeping: read pointer, per-channel reservations, barrier.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_pos    <= '0;
            prev_ch     <= '0;
            bar_valid   <= 1'b0;
            bar_start   <= '0;
            out_barrier <= 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                next_free[c] <= '0;
                done_pos[c]  <= '0;
            end
        end else begin
            if (re) read_pos <= read_pos + POS_ONE;
            out_barrier <= bar_hit;
            if (bar_hit) bar_valid <= 1'b0;
            if (bar_push) begin
                bar_valid <= 1'b1;
                bar_start <= bar_slot;
                for (int c = 0; c < NUM_CHANNELS; c++)
                    next_free[c] <= bar_slot + POS_ONE;
            end else if (grp_push) begin
                next_free[in_channel] <= norm_start + grp_len;
                done_pos[in_channel]  <= norm_start + grp_len - POS_ONE + lat_in;
                prev_ch               <= in_channel;
            end
        end
    end

    // Per-channel issue registers; data fields hold when nothing issues.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            payload_q <= '0;
            addr_q    <= '0;
            thread_q  <= '0;
        end else begin
            valid_q <= hit;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (hit[c]) begin
                    payload_q[c] <= heads[c].payload;
                    addr_q[c]    <= (thread[c] == '0) ? heads[c].base
                                                      : addr_q[c] + heads[c].delta;
                    thread_q[c]  <= thread[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_varray_queue.sv
// Randomised and directed bench for issue_varray_queue. The reference keeps
// a timeline of expected issue events keyed by position: each accepted group
// is expanded at push time into per-thread events with addr = base + k*delta.
module tb_issue_varray_queue;

    localparam int NCH  = 4;
    localparam int MASK = 16'hFFFF;
    localparam int AMSK = 11'h7FF;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_barrier, re;
    logic [1:0]  in_channel;
    logic [4:0]  in_count;
    logic [10:0] in_base, in_delta;
    logic [15:0] in_payload;
    logic [3:0]  out_valid;
    logic [63:0] out_payload;
    logic [43:0] out_addr;
    logic [15:0] out_thread;
    logic        out_barrier, empty;

    // ch0=4, ch1=3, ch2=10, ch3=1
    issue_varray_queue #(.LATENCY({4'd1, 4'd10, 4'd3, 4'd4})) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_channel(in_channel), .in_barrier(in_barrier), .in_count(in_count),
        .in_base(in_base), .in_delta(in_delta), .in_payload(in_payload), .re(re),
        .out_valid(out_valid), .out_payload(out_payload), .out_addr(out_addr),
        .out_thread(out_thread), .out_barrier(out_barrier), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct { int payload; int addr; int thread; bit last; } ev_t;

    const int LAT [NCH] = '{4, 3, 10, 1};

    ev_t ev [int];
    bit  bar_ev [int];
    int  rp, m_prev;
    int  m_nf [NCH], m_done [NCH], occ [NCH];
    int  h_pl [NCH], h_addr [NCH], h_thr [NCH];
    bit  e_v [NCH];
    bit  e_bar, bar_pend;
    int  n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit ge(input int a, input int b);
        return ((a - b) & MASK) < 32768;
    endfunction

    function automatic int mmax(input int a, input int b);
        return ge(a, b) ? a : b;
    endfunction

    function automatic bit m_empty();
        for (int c = 0; c < NCH; c++) if (occ[c] != 0) return 1'b0;
        return !bar_pend;
    endfunction

    task automatic m_reset();
        ev.delete();
        bar_ev.delete();
        rp = 0; m_prev = 0; bar_pend = 0; e_bar = 0;
        for (int c = 0; c < NCH; c++) begin
            m_nf[c] = 0; m_done[c] = 0; occ[c] = 0;
            h_pl[c] = 0; h_addr[c] = 0; h_thr[c] = 0; e_v[c] = 0;
        end
    endtask

    task automatic m_push(input bit bar, input int ch, input int cnt,
                          input int base, input int dlt, input int pl);
        int s;
        ev_t e;
        if (bar) begin
            s = (rp + 1) & MASK;
            for (int c = 0; c < NCH; c++) s = mmax(s, m_done[c]);
            bar_ev[s] = 1'b1;
            bar_pend  = 1'b1;
            for (int c = 0; c < NCH; c++) m_nf[c] = (s + 1) & MASK;
        end else if (cnt != 0) begin
            s = mmax(mmax(m_done[m_prev], m_nf[ch]), (rp + 1) & MASK);
            for (int k = 0; k < cnt; k++) begin
                e.payload = pl;
                e.addr    = (base + k * dlt) & AMSK;
                e.thread  = k;
                e.last    = (k == cnt - 1);
                ev[((s + k) & MASK) * NCH + ch] = e;
            end
            m_nf[ch]   = (s + cnt) & MASK;
            m_done[ch] = (s + cnt - 1 + LAT[ch]) & MASK;
            m_prev     = ch;
            occ[ch]++;
        end
    endtask

    task automatic m_read(input bit r);
        int key;
        e_bar = 1'b0;
        for (int c = 0; c < NCH; c++) e_v[c] = 1'b0;
        if (r) begin
            for (int c = 0; c < NCH; c++) begin
                key = rp * NCH + c;
                if (ev.exists(key)) begin
                    e_v[c]    = 1'b1;
                    h_pl[c]   = ev[key].payload;
                    h_addr[c] = ev[key].addr;
                    h_thr[c]  = ev[key].thread;
                    if (ev[key].last) occ[c]--;
                    ev.delete(key);
                end
            end
            if (bar_ev.exists(rp)) begin
                e_bar    = 1'b1;
                bar_pend = 1'b0;
                bar_ev.delete(rp);
            end
            rp = (rp + 1) & MASK;
        end
    endtask

    task automatic check_outs();
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("valid%0d@%0d", c, rp), 64'(out_valid[c]), 64'(e_v[c]));
            chk($sformatf("payload%0d", c), 64'(out_payload[c*16 +: 16]), 64'(h_pl[c]));
            chk($sformatf("addr%0d", c), 64'(out_addr[c*11 +: 11]), 64'(h_addr[c]));
            chk($sformatf("thread%0d", c), 64'(out_thread[c*4 +: 4]), 64'(h_thr[c]));
        end
        chk("barrier", 64'(out_barrier), 64'(e_bar));
        chk("empty", 64'(empty), 64'(m_empty()));
    endtask

    // One clock: present inputs, check in_ready, step model and DUT, check outputs.
    task automatic cyc(input bit v, input bit bar, input int ch, input int cnt,
                       input int base, input int dlt, input int pl, input bit r);
        bit rdy;
        in_valid   = v;
        in_barrier = bar;
        in_channel = 2'(ch);
        in_count   = 5'(cnt);
        in_base    = 11'(base);
        in_delta   = 11'(dlt);
        in_payload = 16'(pl);
        re         = r;
        #1;
        rdy = bar ? !bar_pend : (occ[ch] < 8);
        chk("in_ready", 64'(in_ready), 64'(rdy));
        if (v && rdy) m_push(bar, ch, cnt, base, dlt, pl);
        m_read(r);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        re       = 1'b0;
        check_outs();
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; re = 1'b0; in_barrier = 1'b0;
        #1;
        chk("ready_in_reset", 64'(in_ready), 64'(0));
        @(posedge clk);
        @(negedge clk);
        m_reset();
        check_outs();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_barrier = 1'b0; re = 1'b0;
        in_channel = '0; in_count = '0; in_base = '0; in_delta = '0; in_payload = '0;
        m_reset();
        @(negedge clk);
        do_reset();

        // Single group of 4 on ch2: addresses 100,103,106,109
        cyc(1, 0, 2, 4, 100, 3, 16'h1234, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 2, 0, 0, 0, 0, 1);

        // ch1 waits for ch0's latency: issues at position 6
        do_reset();
        cyc(1, 0, 0, 2, 10, 1, 16'hA0A0, 0);
        cyc(1, 0, 1, 1, 20, 2, 16'hB1B1, 0);
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1);

        // Barrier behind ch2 latency 10: fires at position 11
        do_reset();
        cyc(1, 0, 2, 1, 5, 0, 16'hC2C2, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1);

        // Fill ch1, check back-pressure, drain until space returns
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 0, 1, 1, i, 1, 16'h0100 + i, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 99, 1, 16'hDEAD, 0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 1, 0, 0, 0, 0, 1);

        // Reset mid-group, then a fresh push starts at position 1
        do_reset();
        cyc(1, 0, 0, 8, 50, 4, 16'h5555, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1);
        do_reset();
        cyc(1, 0, 1, 2, 7, 9, 16'h6666, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1);

        // Randomised traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 16)),
                int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                int'($urandom_range(0, 65535)), $urandom_range(0, 9) < 7);
        end

        // Walk to the wrap point, keeping ch3 reservations fresh, then a
        // group of 4 straddling position 0 with addresses that also wrap
        do_reset();
        while (rp != 65532) begin
            if ((rp & 4095) == 0) cyc(1, 0, 3, 1, rp & AMSK, 1, rp, 1);
            else                  cyc(0, 0, 3, 0, 0, 0, 0, 1);
        end
        cyc(1, 0, 3, 4, 2040, 5, 16'hBEEF, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 3, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/issue_varray_queue.md
# issue_varray_queue

Parametrised successor to the superscalar instruction queue. It accepts one instruction group per cycle for any of `NUM_CHANNELS` execution pipelines and expands each group into `count` consecutive per-thread issues. Groups are scheduled on a shared virtual timeline that honours per-channel latency, and every output is emitted from a single global read pointer. It sits between the program decoder and the DMA, regfile and math pipelines.

## Interface
- `NUM_CHANNELS`, 4: number of pipelines; channel index width `CH_W = $clog2(NUM_CHANNELS)`
- `PAYLOAD_W`, 16: opaque instruction bits per channel
- `ADDR_W`, 11: base/delta/output address width
- `LOG_MAX_COPY`, 4: max group size is `2**LOG_MAX_COPY`
- `DEPTH`, 8: group entries per channel FIFO (power of 2)
- `POS_BITS`, 16: virtual-position counter width
- `LATENCY`, {4'd10,4'd3,4'd4,4'd1}: packed 4-bit latency per channel; channel 0 is the LSB field
- `clk  in  1  clock`
- `reset  in  1  synchronous, active-high`
- `in_valid  in  1  push request`
- `in_ready  out  1  push accepted when in_valid && in_ready`
- `in_channel  in  CH_W  target pipeline`
- `in_barrier  in  1  barrier push; channel/count ignored`
- `in_count  in  LOG_MAX_COPY+1  threads in group, 1..2**LOG_MAX_COPY`
- `in_base, in_delta  in  ADDR_W each  first address, per-thread stride`
- `in_payload  in  PAYLOAD_W  instruction bits`
- `re  in  1  advance read pointer one position`
- `out_valid  out  NUM_CHANNELS  per-channel issue valid`
- `out_payload  out  NUM_CHANNELS*PAYLOAD_W`
- `out_addr  out  NUM_CHANNELS*ADDR_W`
- `out_thread  out  NUM_CHANNELS*LOG_MAX_COPY  thread index within group`
- `out_barrier  out  1  barrier reached`
- `empty  out  1  no pending groups, no barrier pending`

## Operation
- State: `read_pos`, per-channel `next_free[c]` and `done_pos[c]`, `prev_ch`, and a per-channel FIFO of {start, count, base, delta, payload}, plus a 1-entry barrier register.
- Normal push slot: `start = max(done_pos[prev_ch], next_free[in_channel], read_pos+1)`.
- On accept:
  - `next_free[c] = start + count`.
  - `done_pos[c] = start + count - 1 + LATENCY[c]`.
  - `prev_ch = c`.
- Barrier push slot: `start = max over c of done_pos[c]`, also bounded below by `read_pos+1`. It occupies one position and sets every `next_free` to `start+1`.
- All position compares are modular: `a >= b` iff `(a-b)` taken as signed POS_BITS is ≥ 0. Free-running wrap is legal. No reset-on-wrap output.
- `in_ready = !reset && FIFO[in_channel] not full`. For a barrier, `in_ready` requires the barrier register to be empty.
- `in_count == 0` is accepted and discarded with no state change.
- On `re`, for each channel whose head entry satisfies `start <= read_pos < start+count`:
  - Issue `out_valid=1` with the head payload.
  - Address: `out_addr = base` on the first thread, else previous `out_addr + delta`, truncated to ADDR_W.
  - `out_thread = read_pos - start`.
  - The entry pops on its last thread.
- A barrier asserts `out_barrier` for one read at `read_pos == start`.
- `empty` = all FIFOs empty and no barrier pending.

## Timing
- All outputs are registered. The cycle after `re` reflects position `read_pos` sampled at that edge.
- Without `re`, `out_*` valids clear to 0 next cycle; payload, addr and thread hold their values.
- A push is readable no earlier than one cycle later, guaranteed by `start ≥ read_pos+1`.
- Simultaneous push and pop on the same FIFO is allowed when full: a pop in the same cycle frees a slot, but `in_ready` ignores this (conservative).
- Reset values: `read_pos`, `next_free`, `done_pos` = 0; `prev_ch` = 0; FIFOs and barrier empty; `in_ready` = 0 during reset; `out_valid` = 0, `out_barrier` = 0, `out_addr`/`out_payload`/`out_thread` = 0; `empty` = 1.
- Reset mid-group discards all pending state; the next cycle is the empty state.

## Structure
- A shared package holds: position compare/max functions, the FIFO entry struct, and the latency-lookup function.
- One sub-module `issue_group_fifo`, instantiated per channel: DEPTH-entry, 1-cycle FIFO exposing head, full, empty, pop.

## Test plan
- Reset, then push ch2 count 4 base 100 delta 3, then `re` ×6 → ch2 valid for 4 cycles, addr 100, 103, 106, 109, thread 0..3; `empty`=1 afterward.
- Push ch0 count 2 then ch1 count 1 with LATENCY[0]=4 → ch1 issues at `read_pos` 6, not earlier.
- Barrier after ch2 (latency 10) group of 1 at position 1 → `out_barrier` at position 11, with no other valids between.
- Fill ch1 with DEPTH groups → `in_ready`=0 for ch1 and 1 for ch0. Then one pop-completing read → `in_ready`=1 next cycle.
- Preset `read_pos` near 2**POS_BITS-2 with a push spanning the wrap → 4 contiguous issues, correct addresses, no stall.
- Assert reset mid-group → all `out_valid` 0 next cycle, `empty`=1, and a subsequent push starts at position 1.
